// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: issues one req/ack data-memory access per valid LSU op and stalls the core until it finishes.
// Optional macro LSU_MISALIGN_CHECK_EN rejects misaligned halfword/word accesses without touching the bus.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [2:0]  i_lsu_sel,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_done,
  output logic        o_stall,
  output logic        o_bus_err,
  output logic        o_misalign,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] SEL_LW  = 3'b000;
  localparam logic [2:0] SEL_SW  = 3'b001;
  localparam logic [2:0] SEL_LB  = 3'b010;
  localparam logic [2:0] SEL_LBU = 3'b011;
  localparam logic [2:0] SEL_LH  = 3'b100;
  localparam logic [2:0] SEL_LHU = 3'b101;
  localparam logic [2:0] SEL_SB  = 3'b110;
  localparam logic [2:0] SEL_SH  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             mis_q, mis_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             misaligned_c;

  function automatic logic is_store(input logic [2:0] sel);
    return (sel == SEL_SW) || (sel == SEL_SB) || (sel == SEL_SH);
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] sel, input logic [1:0] off);
    case (sel)
      SEL_SB:  store_be = 4'b0001 << off;
      SEL_SH:  store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] sel, input logic [31:0] wd);
    case (sel)
      SEL_SB:  store_data = {4{wd[7:0]}};
      SEL_SH:  store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  // Pick the addressed lane out of the read word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [2:0] sel, input logic [1:0] off,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (sel)
      SEL_LB:  load_extend = {{24{b[7]}}, b};
      SEL_LBU: load_extend = {24'd0, b};
      SEL_LH:  load_extend = {{16{h[15]}}, h};
      SEL_LHU: load_extend = {16'd0, h};
      default: load_extend = rd;
    endcase
  endfunction

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned_c = ((i_lsu_sel == SEL_LH || i_lsu_sel == SEL_LHU || i_lsu_sel == SEL_SH)
                          && i_addr[0])
                     || ((i_lsu_sel == SEL_LW || i_lsu_sel == SEL_SW) && (i_addr[1:0] != 2'b00));
`else
  assign misaligned_c = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mis_d   = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          sel_d = i_lsu_sel;
          off_d = i_addr[1:0];
          cnt_d = '0;
          if (misaligned_c) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = S_BUSY;
            req_d   = 1'b1;
            we_d    = is_store(i_lsu_sel);
            addr_d  = {i_addr[31:2], 2'b00};
            be_d    = is_store(i_lsu_sel) ? store_be(i_lsu_sel, i_addr[1:0]) : 4'b1111;
            wdata_d = store_data(i_lsu_sel, i_wdata);
          end
        end
      end
      S_BUSY: begin
        if (i_mem_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          rdata_d = load_extend(sel_q, off_q, i_mem_rdata);
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      off_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  // Stall drops in DONE so the core advances exactly once per access.
  assign o_stall     = !i_rst && ((state_q == S_IDLE && i_valid) || state_q == S_BUSY);
  assign o_rdata     = rdata_q;
  assign o_done      = done_q;
  assign o_bus_err   = err_q;
  assign o_misalign  = mis_q;
  assign o_mem_req   = req_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_be    = be_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed test-plan cases plus random accesses against a lane model.
module tb_lsu_mem_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_mem_ack;
  logic [2:0]  i_lsu_sel;
  logic [31:0] i_addr, i_wdata, i_mem_rdata;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
  logic        o_done, o_stall, o_bus_err, o_misalign, o_mem_req, o_mem_we;
  logic [3:0]  o_mem_be;

  int total = 0;
  int bad   = 0;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_lsu_sel(i_lsu_sel),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_done(o_done),
    .o_stall(o_stall), .o_bus_err(o_bus_err), .o_misalign(o_misalign),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference rules, expressed per access type rather than per hardware register.
  function automatic bit ref_store(input logic [2:0] sel);
    return sel inside {3'b001, 3'b110, 3'b111};
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] sel, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
    int size;
    size = (sel inside {3'b000, 3'b001}) ? 4 : (sel inside {3'b100, 3'b101, 3'b111}) ? 2 : 1;
    return (a % size) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] sel, input logic [31:0] a);
    logic [3:0] m;
    int base;
    m = 4'b0000;
    if (sel == 3'b110) m[a[1:0]] = 1'b1;
    else if (sel == 3'b111) begin
      base = (a[1:0] >= 2) ? 2 : 0;
      m[base] = 1'b1;
      m[base+1] = 1'b1;
    end else m = 4'b1111;
    return m;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] sel, input logic [31:0] wd);
    logic [31:0] r;
    r = wd;
    if (sel == 3'b110) for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[7:0];
    if (sel == 3'b111) for (int i = 0; i < 2; i++) r[16*i +: 16] = wd[15:0];
    return r;
  endfunction

  function automatic logic [31:0] ref_rdata(input logic [2:0] sel, input logic [31:0] a,
                                            input logic [31:0] rd);
    int lo, n;
    longint v;
    lo = int'(a[1:0]);
    n  = 4;
    if (sel == 3'b010 || sel == 3'b011) n = 1;
    if (sel == 3'b100 || sel == 3'b101) begin n = 2; lo = (lo / 2) * 2; end
    if (n == 4) return rd;
    v = longint'((rd >> (8 * lo)) & ((32'd1 << (8 * n)) - 32'd1));
    if ((sel == 3'b010 || sel == 3'b100) && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  // One access from IDLE; ack_at = BUSY cycle (1-based) that carries ack, 0 = never.
  task automatic run_access(input string tag, input logic [2:0] sel, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
    bit mis;
    int stall_n, req_n, exp_stall;
    mis = ref_misaligned(sel, a);
    i_valid = 1'b1; i_lsu_sel = sel; i_addr = a; i_wdata = wd;
    #1;
    check({tag, ".stall_issue"}, 32'(o_stall), 32'd1);
    stall_n = 1; req_n = 0;
    @(posedge clk); #1;
    i_valid = 1'b0; i_lsu_sel = 3'($urandom); i_addr = $urandom; i_wdata = $urandom;
    if (!mis) begin
      check({tag, ".addr"}, o_mem_addr, {a[31:2], 2'b00});
      check({tag, ".we"}, 32'(o_mem_we), 32'(ref_store(sel)));
      check({tag, ".be"}, 32'(o_mem_be), 32'(ref_be(sel, a)));
      if (ref_store(sel)) check({tag, ".wdata"}, o_mem_wdata, ref_wdata(sel, wd));
    end
    for (int k = 1; k <= 300 && !o_done; k++) begin
      stall_n += int'(o_stall);
      req_n   += int'(o_mem_req);
      if (k == ack_at) begin i_mem_ack = 1'b1; i_mem_rdata = rd; end
      else i_mem_rdata = $urandom;
      @(posedge clk); #1;
      i_mem_ack = 1'b0;
    end
    check({tag, ".done"}, 32'(o_done), 32'd1);
    exp_stall = mis ? 1 : 1 + ((ack_at >= 1 && ack_at <= T) ? ack_at : T);
    check({tag, ".stall_cycles"}, 32'(stall_n), 32'(exp_stall));
    check({tag, ".req_cycles"}, 32'(req_n), 32'(exp_stall - 1));
    check({tag, ".bus_err"}, 32'(o_bus_err), 32'(!mis && !(ack_at >= 1 && ack_at <= T)));
    check({tag, ".misalign"}, 32'(o_misalign), 32'(mis));
    check({tag, ".stall_done"}, 32'(o_stall), 32'd0);
    check({tag, ".req_done"}, 32'(o_mem_req), 32'd0);
    if (mis || !(ack_at >= 1 && ack_at <= T)) check({tag, ".rdata_zero"}, o_rdata, 32'd0);
    else if (!ref_store(sel)) check({tag, ".rdata"}, o_rdata, ref_rdata(sel, a, rd));
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b1; i_lsu_sel = 3'b000; i_addr = 32'h10;
    i_wdata = 0; i_mem_ack = 1'b0; i_mem_rdata = 0;
    #1;
    check("rst.stall", 32'(o_stall), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    i_valid = 1'b0;
    check("rst.outs", {o_rdata[31:4], o_done, o_bus_err, o_misalign, o_mem_req}, 32'd0);
    check("rst.bus", {o_mem_addr[31:5], o_mem_we, o_mem_be}, 32'd0);
    i_rst = 1'b0;
    @(posedge clk); #1;

    run_access("lb",  3'b010, 32'h103, 32'h0, 32'h80FF_1234, 3);
    check("lb.rdata_val", o_rdata, 32'hFFFF_FF80);
    run_access("lhu", 3'b101, 32'h202, 32'h0, 32'h8001_7FFF, 2);
    run_access("lh",  3'b100, 32'h202, 32'h0, 32'h8001_7FFF, 2);
    run_access("sh",  3'b111, 32'h306, 32'h1234_ABCD, 32'h0, 1);
    run_access("lw_timeout", 3'b000, 32'h600, 32'h0, 32'hDEAD_BEEF, 0);
    run_access("sw_401", 3'b001, 32'h401, 32'hCAFE_F00D, 32'h0, 1);

    // Ack while idle must be ignored.
    i_mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_mem_ack = 1'b0;
    check("idle_ack.done", 32'(o_done), 32'd0);
    check("idle_ack.req", 32'(o_mem_req), 32'd0);

    // Reset in the second BUSY cycle, stray ack afterwards.
    i_valid = 1'b1; i_lsu_sel = 3'b000; i_addr = 32'h500;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    check("midrst.req", 32'(o_mem_req), 32'd0);
    check("midrst.stall", 32'(o_stall), 32'd0);
    i_mem_ack = 1'b1; i_mem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    i_mem_ack = 1'b0;
    check("midrst.done0", 32'(o_done), 32'd0);
    @(posedge clk); #1;
    check("midrst.done1", 32'(o_done), 32'd0);
    run_access("lw_after_rst", 3'b000, 32'h504, 32'h0, 32'h1357_9BDF, 2);

    for (int n = 0; n < 40; n++) begin
      run_access("rand", 3'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 6)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
